block_exp_detect: RTL

- Block-floating-point exponent detector feeding compress_shift.
- Scans every sop..eop packet of complex IW-bit samples and finds the largest left shift that keeps all re/im samples free of overflow.
- Presents the shift on o_shift_num for compress_shift's i_shift_num. compress_shift's DLY_CYCLE buffer re-aligns the shift with the same packet's data.

---
 rtl/block_exp_detect.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/block_exp_detect.sv
// Block-floating-point exponent detector: finds the largest overflow-free left
// shift over each sop..eop packet of complex samples, for compress_shift.
module block_exp_detect #(
   parameter int IW        = 40,
   parameter int SHIFT_W   = 5,
   parameter int MAX_SHIFT = 24,
   parameter int LEN_W     = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_sop,
   input  logic               i_eop,
   input  logic               i_vld,
   input  logic [IW-1:0]      i_din_re,
   input  logic [IW-1:0]      i_din_im,
   output logic [SHIFT_W-1:0] o_shift_num,
   output logic               o_shift_vld,
   output logic [LEN_W-1:0]   o_pkt_len,
   output logic               o_pkt_err
);

   localparam int MW = IW - 1;
   localparam int CW = $clog2(IW) + 1;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_ACC
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_inc;

   logic [MW-1:0]    w_mag_re;
   logic [MW-1:0]    w_mag_im;
   logic [MW-1:0]    w_mag;

   logic [MW-1:0]    r_s1_mag;
   logic             r_s1_take;
   logic             r_s1_start;
   logic             r_s1_emit;
   logic [LEN_W-1:0] r_s1_len;

   logic [MW-1:0]    r_acc;
   logic [MW-1:0]    w_acc_next;
   logic [MW-1:0]    r_res;
   logic             r_res_vld;
   logic [LEN_W-1:0] r_res_len;

   logic [CW-1:0]      w_lz;
   logic [SHIFT_W-1:0] w_shift;

   // The sign bit is dropped: for two's complement it carries no magnitude.
   assign w_mag_re  = i_din_re[MW-1:0] ^ {MW{i_din_re[IW-1]}};
   assign w_mag_im  = i_din_im[MW-1:0] ^ {MW{i_din_im[IW-1]}};
   assign w_mag     = w_mag_re | w_mag_im;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // Framing FSM plus stage 1; decisions travel alongside the sample magnitude.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         o_pkt_err  <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_take  <= 1'b0;
         r_s1_start <= 1'b0;
         r_s1_emit  <= 1'b0;
         r_s1_len   <= '0;
      end else begin
         o_pkt_err  <= 1'b0;
         r_s1_take  <= 1'b0;
         r_s1_start <= 1'b0;
         r_s1_emit  <= 1'b0;
         r_s1_mag   <= w_mag;
         if (i_vld) begin
            case (r_state)
               ST_IDLE: begin
                  if (i_sop) begin
                     r_s1_take  <= 1'b1;
                     r_s1_start <= 1'b1;
                     r_s1_len   <= LEN_W'(1);
                     r_cnt      <= LEN_W'(1);
                     if (i_eop) r_s1_emit <= 1'b1;
                     else       r_state   <= ST_ACC;
                  end else if (i_eop) begin
                     o_pkt_err <= 1'b1;
                  end
               end
               ST_ACC: begin
                  r_s1_take <= 1'b1;
                  if (i_sop) begin
                     // Restart: the aborted packet never produces a result.
                     o_pkt_err  <= 1'b1;
                     r_s1_start <= 1'b1;
                     r_s1_len   <= LEN_W'(1);
                     r_cnt      <= LEN_W'(1);
                     if (i_eop) begin
                        r_s1_emit <= 1'b1;
                        r_state   <= ST_IDLE;
                     end
                  end else begin
                     r_cnt    <= w_cnt_inc;
                     r_s1_len <= w_cnt_inc;
                     if (i_eop) begin
                        r_s1_emit <= 1'b1;
                        r_state   <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign w_acc_next = r_s1_start ? r_s1_mag : (r_acc | r_s1_mag);

   // Stage 2: OR accumulation; the eop value is captured so r_acc frees up at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_res     <= '0;
         r_res_vld <= 1'b0;
         r_res_len <= '0;
      end else begin
         r_res_vld <= r_s1_emit;
         if (r_s1_take) r_acc <= w_acc_next;
         if (r_s1_emit) begin
            r_res     <= w_acc_next;
            r_res_len <= r_s1_len;
         end
      end
   end

   always_comb begin
      w_lz = CW'(IW - 1);
      for (int unsigned i = 0; i < MW; i++) begin
         if (r_res[i]) w_lz = CW'(MW - 1 - i);
      end
   end

   assign w_shift = (w_lz > CW'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : SHIFT_W'(w_lz);

   // Stage 3: leading-zero count and clamp registered onto the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_shift_num <= SHIFT_W'(MAX_SHIFT);
         o_shift_vld <= 1'b0;
         o_pkt_len   <= '0;
      end else begin
         o_shift_vld <= r_res_vld;
         if (r_res_vld) begin
            o_shift_num <= w_shift;
            o_pkt_len   <= r_res_len;
         end
      end
   end

endmodule
